// File: rtl/uart_cmd_decoder.sv
// UART command parser driving the signal generator's control registers, with ACK/NAK responses.
// Optional: define CMD_QUERY_EN to make 'S' answer with a status byte instead of a NAK.
module uart_cmd_decoder #(
    parameter int CLK_HZ         = 25000000,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_busy,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic [31:0] freq_div,
    output logic [1:0]  wave_sel,
    output logic        noise_en,
    output logic [1:0]  filter_level,
    output logic        adsr_en,
    output logic [7:0]  attack,
    output logic [7:0]  decay,
    output logic [7:0]  sustain,
    output logic [7:0]  relax,
    output logic        cfg_update
);

    localparam logic [7:0] ACK = 8'h21;
    localparam logic [7:0] NAK = 8'h3F;

    typedef enum logic [1:0] {IDLE, P_SEL, P_HI, P_LO} state_t;

    function automatic logic [31:0] div_for(input logic [2:0] idx);
        case (idx)
            3'd0:    div_for = 32'(CLK_HZ / 250);
            3'd1:    div_for = 32'(CLK_HZ / 500);
            3'd2:    div_for = 32'(CLK_HZ / 750);
            3'd3:    div_for = 32'(CLK_HZ / 1000);
            3'd4:    div_for = 32'(CLK_HZ / 1500);
            3'd5:    div_for = 32'(CLK_HZ / 2000);
            3'd6:    div_for = 32'(CLK_HZ / 3000);
            default: div_for = 32'(CLK_HZ / 4000);
        endcase
    endfunction

    // Returns {valid, nibble}.
    function automatic logic [4:0] hex_val(input logic [7:0] b);
        if (b >= 8'h30 && b <= 8'h39)      hex_val = {1'b1, b[3:0]};
        else if (b >= 8'h41 && b <= 8'h46) hex_val = {1'b1, b[3:0] + 4'd9};
        else if (b >= 8'h61 && b <= 8'h66) hex_val = {1'b1, b[3:0] + 4'd9};
        else                               hex_val = 5'd0;
    endfunction

    state_t      r_state, w_state_next;
    logic [1:0]  r_sel, w_sel_next;
    logic [3:0]  r_hi, w_hi_next;
    logic [31:0] r_timer, w_timer_next;
    logic [31:0] r_freq, w_freq_next;
    logic [1:0]  r_wave, w_wave_next;
    logic        r_noise, w_noise_next;
    logic [1:0]  r_filt, w_filt_next;
    logic        r_adsr, w_adsr_next;
    logic [7:0]  r_att, w_att_next;
    logic [7:0]  r_dec, w_dec_next;
    logic [7:0]  r_sus, w_sus_next;
    logic [7:0]  r_rel, w_rel_next;
    logic        r_cfg_update, w_cfg_update_next;
    logic        r_pend, w_pend_next;
    logic [7:0]  r_pend_data, w_pend_data_next;
    logic        r_tx_en, w_tx_en_next;
    logic [7:0]  r_tx_data, w_tx_data_next;

    logic        w_resp_new;
    logic [7:0]  w_resp_byte;
    logic        w_timeout;
    logic        w_issue;
    logic [4:0]  w_hex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_sel        <= 2'd0;
            r_hi         <= 4'd0;
            r_timer      <= 32'd0;
            r_freq       <= 32'(CLK_HZ / 250);
            r_wave       <= 2'd0;
            r_noise      <= 1'b0;
            r_filt       <= 2'd0;
            r_adsr       <= 1'b0;
            r_att        <= 8'h10;
            r_dec        <= 8'h10;
            r_sus        <= 8'h80;
            r_rel        <= 8'h10;
            r_cfg_update <= 1'b0;
            r_pend       <= 1'b0;
            r_pend_data  <= 8'h00;
            r_tx_en      <= 1'b0;
            r_tx_data    <= 8'h00;
        end else begin
            r_state      <= w_state_next;
            r_sel        <= w_sel_next;
            r_hi         <= w_hi_next;
            r_timer      <= w_timer_next;
            r_freq       <= w_freq_next;
            r_wave       <= w_wave_next;
            r_noise      <= w_noise_next;
            r_filt       <= w_filt_next;
            r_adsr       <= w_adsr_next;
            r_att        <= w_att_next;
            r_dec        <= w_dec_next;
            r_sus        <= w_sus_next;
            r_rel        <= w_rel_next;
            r_cfg_update <= w_cfg_update_next;
            r_pend       <= w_pend_next;
            r_pend_data  <= w_pend_data_next;
            r_tx_en      <= w_tx_en_next;
            r_tx_data    <= w_tx_data_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_hi_next    = r_hi;
        w_freq_next  = r_freq;
        w_wave_next  = r_wave;
        w_noise_next = r_noise;
        w_filt_next  = r_filt;
        w_adsr_next  = r_adsr;
        w_att_next   = r_att;
        w_dec_next   = r_dec;
        w_sus_next   = r_sus;
        w_rel_next   = r_rel;
        w_resp_new   = 1'b0;
        w_resp_byte  = ACK;
        w_hex        = hex_val(rx_data);

        // A byte landing in the expiry cycle wins over the timeout.
        w_timeout    = (r_state != IDLE) && !rx_valid &&
                       (r_timer >= 32'(TIMEOUT_CYCLES - 1));
        w_timer_next = ((r_state == IDLE) || rx_valid) ? 32'd0 : r_timer + 32'd1;

        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    w_resp_new = 1'b1;
                    case (rx_data) inside
                        [8'h30:8'h37]: w_freq_next = div_for(rx_data[2:0]);
                        [8'h41:8'h44]: w_wave_next = rx_data[1:0] - 2'd1;
                        8'h48:         w_noise_next = ~r_noise;
                        8'h49:         w_filt_next = 2'd1;
                        8'h4A:         w_filt_next = 2'd2;
                        8'h4B:         w_filt_next = 2'd3;
                        8'h4E:         w_filt_next = 2'd0;
                        8'h4C:         w_adsr_next = 1'b1;
                        8'h4D:         w_adsr_next = 1'b0;
                        8'h50: begin
                            w_state_next = P_SEL;
                            w_resp_new   = 1'b0;
                        end
                        8'h0D, 8'h0A:  w_resp_new = 1'b0;
`ifdef CMD_QUERY_EN
                        8'h53:         w_resp_byte = {2'b01, r_wave, r_filt, r_noise, r_adsr};
`endif
                        default:       w_resp_byte = NAK;
                    endcase
                end
            end
            P_SEL: begin
                if (rx_valid) begin
                    w_state_next = P_HI;
                    case (rx_data)
                        8'h61:   w_sel_next = 2'd0;
                        8'h64:   w_sel_next = 2'd1;
                        8'h73:   w_sel_next = 2'd2;
                        8'h72:   w_sel_next = 2'd3;
                        default: begin
                            w_state_next = IDLE;
                            w_resp_new   = 1'b1;
                            w_resp_byte  = NAK;
                        end
                    endcase
                end
            end
            P_HI: begin
                if (rx_valid) begin
                    if (w_hex[4]) begin
                        w_hi_next    = w_hex[3:0];
                        w_state_next = P_LO;
                    end else begin
                        w_state_next = IDLE;
                        w_resp_new   = 1'b1;
                        w_resp_byte  = NAK;
                    end
                end
            end
            default: begin
                if (rx_valid) begin
                    w_state_next = IDLE;
                    w_resp_new   = 1'b1;
                    if (w_hex[4]) begin
                        case (r_sel)
                            2'd0:    w_att_next = {r_hi, w_hex[3:0]};
                            2'd1:    w_dec_next = {r_hi, w_hex[3:0]};
                            2'd2:    w_sus_next = {r_hi, w_hex[3:0]};
                            default: w_rel_next = {r_hi, w_hex[3:0]};
                        endcase
                    end else begin
                        w_resp_byte = NAK;
                    end
                end
            end
        endcase

        if (w_timeout) begin
            w_state_next = IDLE;
            w_resp_new   = 1'b1;
            w_resp_byte  = NAK;
        end

        w_cfg_update_next = {w_freq_next, w_wave_next, w_noise_next, w_filt_next, w_adsr_next,
                             w_att_next, w_dec_next, w_sus_next, w_rel_next} !=
                            {r_freq, r_wave, r_noise, r_filt, r_adsr,
                             r_att, r_dec, r_sus, r_rel};

        // The previous tx_en cycle is skipped so the transmitter has time to raise busy.
        w_issue          = r_pend && !tx_busy && !r_tx_en;
        w_tx_en_next     = w_issue;
        w_tx_data_next   = w_issue ? r_pend_data : r_tx_data;
        w_pend_next      = w_resp_new ? 1'b1 : (w_issue ? 1'b0 : r_pend);
        w_pend_data_next = w_resp_new ? w_resp_byte : r_pend_data;
    end

    assign tx_en        = r_tx_en;
    assign tx_data      = r_tx_data;
    assign freq_div     = r_freq;
    assign wave_sel     = r_wave;
    assign noise_en     = r_noise;
    assign filter_level = r_filt;
    assign adsr_en      = r_adsr;
    assign attack       = r_att;
    assign decay        = r_dec;
    assign sustain      = r_sus;
    assign relax        = r_rel;
    assign cfg_update   = r_cfg_update;

endmodule
